// File: rtl/arb_req_queue_pkg.sv
// Shared defaults and helpers for the per-client arbiter request queue.
// Optional error reporting is enabled with the ARB_REQ_QUEUE_ERR_EN macro.
package arb_req_queue_pkg;

    localparam int NUM_CLIENTS_DEF = 4;
    localparam int DATA_W_DEF      = 8;
    localparam int DEPTH_DEF       = 4;

`ifdef ARB_REQ_QUEUE_ERR_EN
    localparam int ERR_W         = 3;
    localparam int ERR_PUSH_FULL = 0;
    localparam int ERR_MULTI_GNT = 1;
    localparam int ERR_GNT_EMPTY = 2;
`endif

    // True when exactly one bit is set; callers zero-extend vectors up to 32 bits.
    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != '0) && ((vec & (vec - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/arb_req_queue_req_fifo.sv
// Single-client synchronous FIFO: push is dropped when full (evaluated before
// any same-cycle pop); pop must only be issued while non-empty.
module req_fifo
    import arb_req_queue_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: reset is synchronous active-low, so it is tested inside a posedge-only block with non-blocking updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_req_queue.sv
// Per-client request queues feeding a one-hot arbiter; pops the granted client
// and registers the payload. Define ARB_REQ_QUEUE_ERR_EN to add sticky err_o.
module arb_req_queue
    import arb_req_queue_pkg::*;
#(
    parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        push_i,
    input  logic [NUM_CLIENTS*DATA_W-1:0] push_data_i,
    output logic [NUM_CLIENTS-1:0]        full_o,
    output logic [NUM_CLIENTS-1:0]        req_o,
    input  logic [NUM_CLIENTS-1:0]        gnt_i,
    output logic                          out_valid_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [$clog2(NUM_CLIENTS)-1:0] out_client_o
`ifdef ARB_REQ_QUEUE_ERR_EN
    ,
    output logic [2:0]                    err_o
`endif
);

    localparam int CLIENT_W = $clog2(NUM_CLIENTS);
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic [NUM_CLIENTS-1:0] fifo_full;
    logic [NUM_CLIENTS-1:0] fifo_empty;
    logic [NUM_CLIENTS-1:0] pop;
    logic [DATA_W-1:0]      fifo_data  [NUM_CLIENTS];
    logic [CNT_W-1:0]       fifo_count [NUM_CLIENTS];
    logic                   gnt_onehot;
    logic                   gnt_legal;
    logic [CLIENT_W-1:0]    gnt_idx;

    for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_client
        req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push_i[k]),
            .push_data (push_data_i[k*DATA_W +: DATA_W]),
            .pop       (pop[k]),
            .pop_data  (fifo_data[k]),
            .full      (fifo_full[k]),
            .empty     (fifo_empty[k]),
            .count     (fifo_count[k])
        );
        assign req_o[k] = (fifo_count[k] != '0);
    end

    assign full_o = fifo_full;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (gnt_i[k]) gnt_idx = CLIENT_W'(k);
        end
    end

    // Multi-hot grants and stale grants to drained queues are both dropped here.
    assign gnt_onehot = is_onehot(32'(gnt_i));
    assign gnt_legal  = gnt_onehot && !fifo_empty[gnt_idx];
    assign pop        = gnt_legal ? gnt_i : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            out_client_o <= '0;
        end else begin
            out_valid_o <= gnt_legal;
            if (gnt_legal) begin
                out_data_o   <= fifo_data[gnt_idx];
                out_client_o <= gnt_idx;
            end
        end
    end

`ifdef ARB_REQ_QUEUE_ERR_EN
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            if (|(push_i & fifo_full))              err_q[ERR_PUSH_FULL] <= 1'b1;
            if ((gnt_i != '0) && !gnt_onehot)       err_q[ERR_MULTI_GNT] <= 1'b1;
            if (gnt_onehot && fifo_empty[gnt_idx])  err_q[ERR_GNT_EMPTY] <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Self-checking bench for arb_req_queue: queue-based reference model compared
// every cycle, plus directed vectors with literal expectations.
module tb_arb_req_queue;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  push_i;
    logic [N*DW-1:0] push_data_i;
    logic [N-1:0]  full_o;
    logic [N-1:0]  req_o;
    logic [N-1:0]  gnt_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    out_client_o;
`ifdef ARB_REQ_QUEUE_ERR_EN
    logic [2:0]    err_o;
`endif

    always #5 clk = ~clk;

    arb_req_queue #(.NUM_CLIENTS(N), .DATA_W(DW), .DEPTH(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_i),
        .push_data_i  (push_data_i),
        .full_o       (full_o),
        .req_o        (req_o),
        .gnt_i        (gnt_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_client_o (out_client_o)
`ifdef ARB_REQ_QUEUE_ERR_EN
        ,
        .err_o        (err_o)
`endif
    );

    // Reference model: one queue per client plus the expected output register.
    logic [DW-1:0] mq [N][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_client;
    logic [2:0]    m_err;
    logic [N-1:0]  exp_req;
    logic [N-1:0]  exp_full;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;
    int  rr       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slot(input int k, input logic [7:0] v);
        return 32'(v) << (8 * k);
    endfunction

    task automatic model_step();
        bit was_full [N];
        int nhot;
        int idx;
        if (!reset) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            m_valid  = 1'b0;
            m_data   = '0;
            m_client = '0;
            m_err    = '0;
        end else begin
            for (int k = 0; k < N; k++) was_full[k] = (mq[k].size() == D);
            nhot = $countones(gnt_i);
            idx  = 0;
            for (int k = 0; k < N; k++) if (gnt_i[k]) idx = k;
            m_valid = 1'b0;
            if (nhot == 1 && mq[idx].size() > 0) begin
                m_data   = mq[idx].pop_front();
                m_client = 2'(idx);
                m_valid  = 1'b1;
            end else if (nhot == 1) begin
                m_err[2] = 1'b1;
            end else if (nhot > 1) begin
                m_err[1] = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                if (push_i[k]) begin
                    if (was_full[k]) m_err[0] = 1'b1;
                    else mq[k].push_back(push_data_i[k*DW +: DW]);
                end
            end
        end
    endtask

    // Drive inputs, let one rising edge consume them, advance the model, then
    // return on the following falling edge where outputs are sampled.
    task automatic apply(input logic [N-1:0] p, input logic [31:0] d,
                         input logic [N-1:0] g, input logic r = 1'b1);
        push_i      = p;
        push_data_i = d;
        gnt_i       = g;
        reset       = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] rr_grant();
        logic [N-1:0] g;
        bit found;
        g = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            int c;
            c = (rr + off) % N;
            if (!found && mq[c].size() > 0) begin
                g[c]  = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                exp_req[k]  = (mq[k].size() != 0);
                exp_full[k] = (mq[k].size() == D);
            end
            check("cmp_req",        32'(req_o),        32'(exp_req));
            check("cmp_full",       32'(full_o),       32'(exp_full));
            check("cmp_out_valid",  32'(out_valid_o),  32'(m_valid));
            check("cmp_out_data",   32'(out_data_o),   32'(m_data));
            check("cmp_out_client", 32'(out_client_o), 32'(m_client));
`ifdef ARB_REQ_QUEUE_ERR_EN
            check("cmp_err",        32'(err_o),        32'(m_err));
`endif
        end
    end

    initial begin
        logic [N-1:0] g;
        int guard;

        reset       = 1'b0;
        push_i      = '0;
        push_data_i = '0;
        gnt_i       = '0;
        apply('0, '0, '0, 1'b0);
        apply('0, '0, '0, 1'b0);
        chk_en = 1'b1;

        check("rst_req",    32'(req_o),        32'h0);
        check("rst_full",   32'(full_o),       32'h0);
        check("rst_valid",  32'(out_valid_o),  32'h0);
        check("rst_data",   32'(out_data_o),   32'h0);
        check("rst_client", 32'(out_client_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            apply('0, '0, '0);
            check("idle_req", 32'(req_o), 32'h0);
        end

        // Single push then grant to client 2.
        apply(4'b0100, slot(2, 8'hA5), '0);
        check("c2_req", 32'(req_o), 32'h4);
        apply('0, '0, '0);
        apply('0, '0, 4'b0100);
        check("c2_valid",  32'(out_valid_o),  32'h1);
        check("c2_data",   32'(out_data_o),   32'hA5);
        check("c2_client", 32'(out_client_o), 32'h2);
        check("c2_req_drop", 32'(req_o),      32'h0);
        apply('0, '0, '0);
        check("c2_valid_low", 32'(out_valid_o), 32'h0);
        check("c2_data_hold", 32'(out_data_o),  32'hA5);

        // Fill client 0, overflow push dropped, drain in order.
        for (int i = 0; i < 4; i++) apply(4'b0001, slot(0, 8'(8'h10 + i)), '0);
        check("c0_full", 32'(full_o), 32'h1);
        apply(4'b0001, slot(0, 8'h14), '0);
        check("c0_full_after_drop", 32'(full_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            apply('0, '0, 4'b0001);
            check("c0_beat_valid", 32'(out_valid_o), 32'h1);
            check("c0_beat_data",  32'(out_data_o),  32'(8'h10 + i));
        end
        check("c0_empty", 32'(req_o), 32'h0);
`ifdef ARB_REQ_QUEUE_ERR_EN
        check("err_push_full", 32'(err_o[0]), 32'h1);
`endif

        // Client 1 full with simultaneous push and grant.
        for (int i = 0; i < 4; i++) apply(4'b0010, slot(1, 8'(8'h20 + i)), '0);
        apply(4'b0010, slot(1, 8'h77), 4'b0010);
        check("c1_pop_data", 32'(out_data_o), 32'h20);
        check("c1_not_full", 32'(full_o),     32'h0);
        for (int i = 1; i < 4; i++) begin
            apply('0, '0, 4'b0010);
            check("c1_beat_data", 32'(out_data_o), 32'(8'h20 + i));
        end
        check("c1_drained", 32'(req_o), 32'h0);

        // Multi-hot grant and stale grant are ignored.
        apply(4'b0011, slot(0, 8'h31) | slot(1, 8'h32), '0);
        apply('0, '0, 4'b0011);
        check("mh_valid", 32'(out_valid_o), 32'h0);
        check("mh_req",   32'(req_o),       32'h3);
        apply('0, '0, 4'b1000);
        check("stale_valid", 32'(out_valid_o), 32'h0);
        check("stale_hold",  32'(out_data_o),  32'h23);
`ifdef ARB_REQ_QUEUE_ERR_EN
        check("err_all", 32'(err_o), 32'h7);
`endif
        apply('0, '0, 4'b0001);
        check("mh_drain0", 32'(out_data_o), 32'h31);
        apply('0, '0, 4'b0010);
        check("mh_drain1", 32'(out_data_o), 32'h32);

        // Random pushes with a round-robin arbiter; reset mid-run.
        for (int cyc = 0; cyc < 200; cyc++) begin
            g = rr_grant();
            for (int k = 0; k < N; k++) if (g[k]) rr = (k + 1) % N;
            apply(4'($urandom_range(0, 15)), $urandom, g, (cyc == 100) ? 1'b0 : 1'b1);
            if (cyc == 100) begin
                check("midrst_req",   32'(req_o),       32'h0);
                check("midrst_full",  32'(full_o),      32'h0);
                check("midrst_valid", 32'(out_valid_o), 32'h0);
            end
        end

        guard = 0;
        while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0 && guard < 40) begin
            g = rr_grant();
            for (int k = 0; k < N; k++) if (g[k]) rr = (k + 1) % N;
            apply('0, '0, g);
            guard++;
        end
        check("drain_done", 32'(req_o), 32'h0);
        apply('0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_req_queue.md
# arb_req_queue

Per-client request queue sitting directly upstream of the 4-way round-robin arbiter. Buffers up to DEPTH pending requests (with payload) per client, drives the arbiter's request vector from queue occupancy, and on a one-hot grant pops the granted client's oldest entry. The popped payload is presented one cycle later, tagged with the client index, to the downstream consumer.

## Interface
Parameters:
- NUM_CLIENTS, 4, number of clients; must match the arbiter width
- DATA_W, 8, payload width per request
- DEPTH, 4, entries per client queue; power of two, ≥2

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- push_i  in  NUM_CLIENTS  per-client enqueue strobe
- push_data_i  in  NUM_CLIENTS*DATA_W  payloads; client k occupies bits [k*DATA_W +: DATA_W]
- full_o  out  NUM_CLIENTS  per-client queue full
- req_o  out  NUM_CLIENTS  per-client queue non-empty; feeds the arbiter request input
- gnt_i  in  NUM_CLIENTS  grant vector from the arbiter
- out_valid_o  out  1  popped entry valid
- out_data_o  out  DATA_W  popped payload
- out_client_o  out  $clog2(NUM_CLIENTS)  index of the client popped

## Operation
- Each client has an independent FIFO with a count of $clog2(DEPTH)+1 bits and wrap-around read/write pointers.
- Push: `push_i[k]=1` with `full_o[k]=0` writes `push_data_i` slice k at the write pointer and increments the count. A push when full is dropped and the queue is unchanged.
- Push and grant on the same queue in the same cycle:
  - Pop and write both occur; the count is unchanged.
  - `full_o` is evaluated before the pop, so a push into a full queue is dropped even with a simultaneous pop.
- Grant legality:
  - `gnt_i` one-hot with the target queue non-empty: pop that queue.
  - `gnt_i` all zero: no pop, `out_valid_o=0` next cycle.
  - Multi-hot `gnt_i`: ignored entirely; no pop.
  - One-hot grant to an empty queue: ignored; no pop. This tolerates a stale grant issued against a request that has since been drained.
- `req_o[k] = (count_k != 0)`, driven combinationally from registered state.
- `full_o[k] = (count_k == DEPTH)`, driven combinationally from registered state.
- Output register: on a legal pop, `out_valid_o` is 1 next cycle with the popped data and client index. Otherwise `out_valid_o=0`, and `out_data_o`/`out_client_o` hold their previous values.
- No backpressure on the output; the consumer must accept every valid beat.

## Timing
- Reset values: all counts and pointers 0, `req_o=0`, `full_o=0`, `out_valid_o=0`, `out_data_o=0`, `out_client_o=0`. FIFO storage is not reset.
- Reset asserted mid-operation flushes all queued entries at that edge. A push or grant in the reset cycle is ignored.
- Push to an empty queue at edge t: `req_o[k]=1` from t onward (one-cycle latency from the strobe).
- Grant sampled at edge t: entry is popped and `out_valid_o` is asserted after edge t (one-cycle grant-to-data latency). `req_o` drops in the same cycle if the queue became empty.
- Sustained one-hot grants to a queue with ≥N entries yield N back-to-back valid beats.

## Configuration
- Macro `ARB_REQ_QUEUE_ERR_EN`.
- Defined: adds output `err_o`, 3 bits, sticky, cleared only by reset:
  - [0] push dropped due to full
  - [1] multi-hot grant
  - [2] grant to an empty queue
- Each bit sets on the edge following the event.
- Undefined: port and logic absent; the events are still silently ignored as described above.

## Structure
- `arb_req_queue_pkg`: default NUM_CLIENTS/DATA_W/DEPTH localparams, an onehot-check function, and (under the macro) the err bit index constants.
- Sub-module `req_fifo`: single-client synchronous FIFO with push/pop/full/empty/count, instantiated NUM_CLIENTS times in a generate loop.
- The top level holds grant decode, legality check, output register and error logic.

## Test plan
- Reset then idle: all outputs 0; `req_o=4'h0` for 4 cycles.
- Push client 2 data 0xA5 at t0; `gnt_i=4'b0100` at t2: `req_o=4'b0100` after t0; `out_valid_o=1`, `out_data_o=0xA5`, `out_client_o=2` after t2; `req_o=0`.
- Fill client 0 with 0x10..0x13, then push 0x14: `full_o[0]=1`, 0x14 dropped. Grant 4 cycles: beats 0x10..0x13 in order; `err_o[0]=1` if enabled.
- Client 1 full with simultaneous push 0x77 and grant: one pop, push dropped, count 3.
- `gnt_i=4'b0011`, then `gnt_i=4'b1000` with client 3 empty: no pops, `out_valid_o=0`; `err_o[1]`/`err_o[2]` set if enabled.
- Random pushes with a round-robin arbiter connected for 200 cycles: every pushed payload emerges exactly once, in per-client FIFO order; assert reset mid-run and check all queues read empty.
